// File: rtl/uart_link.sv
// 8N1 UART: one 16x oversampling tick generator shared by a transmitter and a receiver.
// Optional: define UART_FRAME_ERR_EN to add o_rx_frame_err (stop bit checked at mid-bit).
module uart_link #(
  parameter int NB_DATA          = 8,
  parameter int NCYCLES_PER_TICK = 163,
  parameter int SB_TICK          = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_tx_data,
  input  logic               i_rx,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
`ifdef UART_FRAME_ERR_EN
  output logic               o_rx_frame_err,
`endif
  output logic               o_tick
);

  localparam int CW = (NCYCLES_PER_TICK > 2) ? $clog2(NCYCLES_PER_TICK) : 1;
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (NB_DATA > 2) ? $clog2(NB_DATA) : 1;

  localparam logic [CW-1:0] C_ZERO   = CW'(0);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NCYCLES_PER_TICK - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(NCYCLES_PER_TICK - 2);
  localparam logic [SW-1:0] S_ZERO   = SW'(0);
  localparam logic [SW-1:0] S_ONE    = SW'(1);
  localparam logic [SW-1:0] BIT_LAST = SW'(15);
  localparam logic [SW-1:0] MID_BIT  = SW'(7);
  localparam logic [SW-1:0] SB_LAST  = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_ZERO   = NW'(0);
  localparam logic [NW-1:0] N_ONE    = NW'(1);
  localparam logic [NW-1:0] NB_LAST  = NW'(NB_DATA - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [CW-1:0] tick_cnt_r;
  logic          tick_r;

  state_t              tx_state_r, tx_state_s;
  logic [SW-1:0]       tx_tick_cnt_r, tx_tick_cnt_s;
  logic [NW-1:0]       tx_bit_cnt_r, tx_bit_cnt_s;
  logic [NB_DATA-1:0]  tx_shift_r, tx_shift_s;
  logic                tx_r, tx_s;
  logic                tx_done_r, tx_done_s;

  logic                rx_meta_r, rx_sync_r;
  state_t              rx_state_r, rx_state_s;
  logic [SW-1:0]       rx_tick_cnt_r, rx_tick_cnt_s;
  logic [NW-1:0]       rx_bit_cnt_r, rx_bit_cnt_s;
  logic [NB_DATA-1:0]  rx_shift_r, rx_shift_s;
  logic [NB_DATA-1:0]  rx_data_r;
  logic                rx_done_r, rx_done_s;

  // Tick divider; o_tick is registered so it is high exactly while the counter sits at its last value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tick_cnt_r <= C_ZERO;
      tick_r     <= 1'b0;
    end else begin
      if (tick_cnt_r == CNT_LAST) begin
        tick_cnt_r <= C_ZERO;
      end else begin
        tick_cnt_r <= tick_cnt_r + C_ONE;
      end
      tick_r <= (tick_cnt_r == CNT_PRE);
    end
  end

  // TX state and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_state_r    <= IDLE;
      tx_tick_cnt_r <= S_ZERO;
      tx_bit_cnt_r  <= N_ZERO;
      tx_shift_r    <= {NB_DATA{1'b0}};
      tx_r          <= 1'b1;
      tx_done_r     <= 1'b0;
    end else begin
      tx_state_r    <= tx_state_s;
      tx_tick_cnt_r <= tx_tick_cnt_s;
      tx_bit_cnt_r  <= tx_bit_cnt_s;
      tx_shift_r    <= tx_shift_s;
      tx_r          <= tx_s;
      tx_done_r     <= tx_done_s;
    end
  end

  // TX next-state and line value
  always_comb begin
    tx_state_s    = tx_state_r;
    tx_tick_cnt_s = tx_tick_cnt_r;
    tx_bit_cnt_s  = tx_bit_cnt_r;
    tx_shift_s    = tx_shift_r;
    tx_s          = 1'b1;
    tx_done_s     = 1'b0;
    case (tx_state_r)
      IDLE: begin
        if (i_tx_start) begin
          tx_shift_s    = i_tx_data;
          tx_tick_cnt_s = S_ZERO;
          tx_state_s    = START;
        end else begin
          tx_state_s = IDLE;
        end
      end
      START: begin
        tx_s = 1'b0;
        if (tick_r) begin
          if (tx_tick_cnt_r == BIT_LAST) begin
            tx_tick_cnt_s = S_ZERO;
            tx_bit_cnt_s  = N_ZERO;
            tx_state_s    = DATA;
          end else begin
            tx_tick_cnt_s = tx_tick_cnt_r + S_ONE;
          end
        end else begin
          tx_tick_cnt_s = tx_tick_cnt_r;
        end
      end
      DATA: begin
        tx_s = tx_shift_r[0];
        if (tick_r) begin
          if (tx_tick_cnt_r == BIT_LAST) begin
            tx_tick_cnt_s = S_ZERO;
            tx_shift_s    = {1'b0, tx_shift_r[NB_DATA-1:1]};
            if (tx_bit_cnt_r == NB_LAST) begin
              tx_state_s = STOP;
            end else begin
              tx_bit_cnt_s = tx_bit_cnt_r + N_ONE;
            end
          end else begin
            tx_tick_cnt_s = tx_tick_cnt_r + S_ONE;
          end
        end else begin
          tx_tick_cnt_s = tx_tick_cnt_r;
        end
      end
      STOP: begin
        tx_s = 1'b1;
        if (tick_r) begin
          if (tx_tick_cnt_r == SB_LAST) begin
            tx_tick_cnt_s = S_ZERO;
            tx_done_s     = 1'b1;
            tx_state_s    = IDLE;
          end else begin
            tx_tick_cnt_s = tx_tick_cnt_r + S_ONE;
          end
        end else begin
          tx_tick_cnt_s = tx_tick_cnt_r;
        end
      end
      default: begin
        tx_state_s = IDLE;
      end
    endcase
  end

  // Two-flop synchronizer for the asynchronous serial input (idles high)
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= i_rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // RX state registers; received byte is published only with the done pulse
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_state_r    <= IDLE;
      rx_tick_cnt_r <= S_ZERO;
      rx_bit_cnt_r  <= N_ZERO;
      rx_shift_r    <= {NB_DATA{1'b0}};
      rx_data_r     <= {NB_DATA{1'b0}};
      rx_done_r     <= 1'b0;
    end else begin
      rx_state_r    <= rx_state_s;
      rx_tick_cnt_r <= rx_tick_cnt_s;
      rx_bit_cnt_r  <= rx_bit_cnt_s;
      rx_shift_r    <= rx_shift_s;
      rx_done_r     <= rx_done_s;
      if (rx_done_s) begin
        rx_data_r <= rx_shift_r;
      end else begin
        rx_data_r <= rx_data_r;
      end
    end
  end

  // RX next-state: the start bit is re-checked at its centre, then every bit is sampled mid-bit
  always_comb begin
    rx_state_s    = rx_state_r;
    rx_tick_cnt_s = rx_tick_cnt_r;
    rx_bit_cnt_s  = rx_bit_cnt_r;
    rx_shift_s    = rx_shift_r;
    rx_done_s     = 1'b0;
    case (rx_state_r)
      IDLE: begin
        if (!rx_sync_r) begin
          rx_tick_cnt_s = S_ZERO;
          rx_state_s    = START;
        end else begin
          rx_state_s = IDLE;
        end
      end
      START: begin
        if (tick_r) begin
          if (rx_tick_cnt_r == MID_BIT) begin
            rx_tick_cnt_s = S_ZERO;
            if (!rx_sync_r) begin
              rx_bit_cnt_s = N_ZERO;
              rx_state_s   = DATA;
            end else begin
              rx_state_s = IDLE;
            end
          end else begin
            rx_tick_cnt_s = rx_tick_cnt_r + S_ONE;
          end
        end else begin
          rx_tick_cnt_s = rx_tick_cnt_r;
        end
      end
      DATA: begin
        if (tick_r) begin
          if (rx_tick_cnt_r == BIT_LAST) begin
            rx_tick_cnt_s = S_ZERO;
            rx_shift_s    = {rx_sync_r, rx_shift_r[NB_DATA-1:1]};
            if (rx_bit_cnt_r == NB_LAST) begin
              rx_state_s = STOP;
            end else begin
              rx_bit_cnt_s = rx_bit_cnt_r + N_ONE;
            end
          end else begin
            rx_tick_cnt_s = rx_tick_cnt_r + S_ONE;
          end
        end else begin
          rx_tick_cnt_s = rx_tick_cnt_r;
        end
      end
      STOP: begin
        if (tick_r) begin
          if (rx_tick_cnt_r == SB_LAST) begin
            rx_tick_cnt_s = S_ZERO;
            rx_done_s     = 1'b1;
            rx_state_s    = IDLE;
          end else begin
            rx_tick_cnt_s = rx_tick_cnt_r + S_ONE;
          end
        end else begin
          rx_tick_cnt_s = rx_tick_cnt_r;
        end
      end
      default: begin
        rx_state_s = IDLE;
      end
    endcase
  end

`ifdef UART_FRAME_ERR_EN
  logic rx_frame_err_r;

  // Stop-bit level is the line value at the moment the done pulse is generated (mid stop bit)
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_frame_err_r <= 1'b0;
    end else begin
      rx_frame_err_r <= rx_done_s & ~rx_sync_r;
    end
  end

  assign o_rx_frame_err = rx_frame_err_r;
`endif

  assign o_tick    = tick_r;
  assign o_tx      = tx_r;
  assign o_tx_done = tx_done_r;
  assign o_rx_data = rx_data_r;
  assign o_rx_done = rx_done_r;

endmodule

// File: tb/tb_uart_link.sv
// Directed bench for uart_link, mostly in loopback; uses a short tick period to keep runs small.
module tb_uart_link;

  localparam int TPT   = 3;
  localparam int BIT   = 16 * TPT;
  localparam int HALF  = BIT / 2;
  localparam int FRAME = 160 * TPT;
  localparam int LIMIT = FRAME + 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       rx_line, rx_drv, loop_en;
  logic       tx, tx_done, rx_done, tick;
  logic [7:0] rx_data;
`ifdef UART_FRAME_ERR_EN
  logic       rx_frame_err;
`endif

  int         check_cnt = 0;
  int         pass_cnt  = 0;
  int         tx_done_cnt = 0;
  int         rx_done_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] rx_at_txdone = 8'h00;
  logic [7:0] rx_at_rxdone = 8'h00;
  logic       err_at_rxdone = 1'b0;

  always #5 clk = ~clk;
  assign rx_line = loop_en ? tx : rx_drv;

  uart_link #(.NB_DATA(8), .NCYCLES_PER_TICK(TPT), .SB_TICK(16)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_tx_start     (tx_start),
    .i_tx_data      (tx_data),
    .i_rx           (rx_line),
    .o_tx           (tx),
    .o_tx_done      (tx_done),
    .o_rx_data      (rx_data),
    .o_rx_done      (rx_done),
`ifdef UART_FRAME_ERR_EN
    .o_rx_frame_err (rx_frame_err),
`endif
    .o_tick         (tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (tx_done === 1'b1) begin
      tx_done_cnt++;
      rx_at_txdone = rx_data;
    end
    if (rx_done === 1'b1) begin
      rx_done_cnt++;
      rx_at_rxdone = rx_data;
`ifdef UART_FRAME_ERR_EN
      err_at_rxdone = rx_frame_err;
`endif
    end
`ifdef UART_FRAME_ERR_EN
    if (rx_frame_err === 1'b1) err_cnt++;
`endif
  end

  // Send a byte from the current falling edge and wait (bounded) for o_tx_done
  task automatic xfer(input logic [7:0] d, output logic ok);
    int c;
    tx_data  = d;
    tx_start = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      tx_start = 1'b0;
      c++;
    end while (tx_done !== 1'b1 && c < LIMIT);
    ok = (tx_done === 1'b1);
  endtask

  initial begin
    #(200_000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ok;
    int         c, tfall, tdone, idx, n_tx, n_rx;
    logic [9:0] frame, got;
    logic [7:0] b;

    rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00; rx_drv = 1'b1; loop_en = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_outs", 32'({tx, tx_done, rx_done, rx_data, tick}), 32'({1'b1, 1'b0, 1'b0, 8'h00, 1'b0}));
    end
    rst = 1'b0;
    @(negedge clk);
    check("idle_outs", 32'({tx, tx_done, rx_done, rx_data}), 32'({1'b1, 1'b0, 1'b0, 8'h00}));

    // Tick: one cycle wide, TPT cycles apart
    for (int k = 0; k < 2; k++) begin
      c = 0;
      while (tick !== 1'b1 && c < 4 * TPT) begin @(negedge clk); c++; end
      @(negedge clk);
      check("tick_width", 32'(tick), 32'(0));
      c = 1;
      while (tick !== 1'b1 && c < 4 * TPT) begin @(negedge clk); c++; end
      check("tick_period", c, TPT);
    end

    // 0xA5 in loopback: bit pattern on the line, done latency, received byte
    frame = {1'b1, 8'hA5, 1'b0};
    got = 10'h000; idx = 0; tfall = -1; tdone = -1;
    tx_data = 8'hA5; tx_start = 1'b1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      tx_start = 1'b0;
      if (tfall < 0 && tx == 1'b0) tfall = k;
      if (tfall >= 0 && k >= tfall + HALF && ((k - tfall - HALF) % BIT) == 0 && idx < 10) begin
        got[idx] = tx;
        idx++;
      end
      if (tx_done === 1'b1) begin
        tdone = k;
        break;
      end
    end
    check("a5_nbits", idx, 10);
    for (int i = 0; i < 10; i++) check("a5_bit", 32'(got[i]), 32'(frame[i]));
    check("a5_done_lat", 32'(tdone >= FRAME - 2 && tdone <= FRAME + TPT + 2), 32'(1));
    check("a5_rx_data", 32'(rx_at_txdone), 32'h0000_00A5);
    check("a5_rx_cnt", rx_done_cnt, 1);
    check("a5_tx_cnt", tx_done_cnt, 1);

    // Back-to-back random bytes, each started the cycle after the previous done
    for (int i = 0; i < 100; i++) begin
      b = 8'($urandom);
      xfer(b, ok);
      check("rand_done", 32'(ok), 32'(1));
      check("rand_byte", 32'(rx_at_txdone), 32'(b));
    end
    check("rand_rx_cnt", rx_done_cnt, 101);

    // Start request while busy is ignored
    n_tx = tx_done_cnt; n_rx = rx_done_cnt; tdone = -1;
    tx_data = 8'h00; tx_start = 1'b1;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      tx_start = 1'b0;
      if (k == 3 * BIT) begin tx_data = 8'h3C; tx_start = 1'b1; end
      if (tx_done === 1'b1) begin tdone = k; break; end
    end
    check("busy_done_seen", 32'(tdone > 0), 32'(1));
    repeat (2 * FRAME) @(negedge clk);
    check("busy_tx_cnt", tx_done_cnt - n_tx, 1);
    check("busy_rx_cnt", rx_done_cnt - n_rx, 1);
    check("busy_rx_data", 32'(rx_data), 32'h0000_0000);

    // Short low glitch on rx is rejected at the start-bit centre
    loop_en = 1'b0; rx_drv = 1'b1; n_rx = rx_done_cnt;
    repeat (4) @(negedge clk);
    rx_drv = 1'b0;
    repeat (3 * TPT) @(negedge clk);
    rx_drv = 1'b1;
    repeat (FRAME + BIT) @(negedge clk);
    check("glitch_rx_cnt", rx_done_cnt - n_rx, 0);
    check("glitch_rx_data", 32'(rx_data), 32'h0000_0000);

    // Reset during DATA aborts the frame silently; the link then works again
    loop_en = 1'b1; n_tx = tx_done_cnt; n_rx = rx_done_cnt;
    tx_data = 8'h00; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (5 * BIT) @(negedge clk);
    check("pre_rst_tx_low", 32'(tx), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    check("rst_tx_high", 32'(tx), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    check("rst_tx_idle", 32'(tx), 32'(1));
    check("rst_tx_cnt", tx_done_cnt - n_tx, 0);
    check("rst_rx_cnt", rx_done_cnt - n_rx, 0);
    check("rst_rx_data", 32'(rx_data), 32'h0000_0000);
    xfer(8'h5A, ok);
    check("post_rst_done", 32'(ok), 32'(1));
    check("post_rst_data", 32'(rx_at_txdone), 32'h0000_005A);
    check("post_rst_rx_cnt", rx_done_cnt - n_rx, 1);

`ifdef UART_FRAME_ERR_EN
    check("no_err_on_good", err_cnt, 0);
`endif

    // Externally driven 0x81 frame with a low stop bit
    loop_en = 1'b0; rx_drv = 1'b1; n_rx = rx_done_cnt;
    repeat (BIT) @(negedge clk);
    frame = {1'b0, 8'h81, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = frame[i];
      repeat ((i == 9) ? (3 * BIT / 4) : BIT) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("ferr_rx_cnt", rx_done_cnt - n_rx, 1);
    check("ferr_rx_data", 32'(rx_at_rxdone), 32'h0000_0081);
    check("ferr_rx_hold", 32'(rx_data), 32'h0000_0081);
`ifdef UART_FRAME_ERR_EN
    check("ferr_flag", 32'(err_at_rxdone), 32'(1));
    check("ferr_cnt", err_cnt, 1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
